onehot_scan_decoder: RTL

Parametrised, registered binary-to-one-hot decoder that generalises the fixed 3-to-8 decoder to SEL_W inputs and 2^SEL_W outputs. It adds enable, selectable output polarity, and an auto-scan mode in which an internal counter walks the active output across all positions with a programmable dwell time. It sits between control logic and multiplexed displays or LED/digit-select lines.

---
 rtl/onehot_pkg.sv | 13 +
 rtl/dwell_counter.sv | 26 ++
 rtl/onehot_scan_decoder.sv | 66 ++++++
 3 files changed

// File: rtl/onehot_pkg.sv
// onehot_pkg: shared one-hot helpers for decoder blocks
package onehot_pkg;
  localparam int unsigned ONEHOT_MAX_W = 256;
  localparam int unsigned SEL_W_DEFAULT = 3;
  localparam int unsigned N_DEFAULT = 1 << SEL_W_DEFAULT;
  function automatic int unsigned onehot_n(input int unsigned sel_w);
    return 1 << sel_w;
  endfunction
  // Bit idx set when idx is inside width; callers cast down to their own width.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx, input int unsigned width);
    return (idx < width) ? (ONEHOT_MAX_W'(1) << idx) : '0;
  endfunction
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts run cycles, ticks and reloads when cnt reaches dwell
//   clk, rst : clock, synchronous active-high reset
//   run      : advance the count this cycle
//   clear    : force count to 0 (lower priority than rst, higher than run)
//   dwell    : live dwell limit
//   tick     : high while running and cnt >= dwell
module dwell_counter
  import onehot_pkg::*;
#(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               clear,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);
  logic [DWELL_W-1:0] r_cnt;
  // >= rather than == so a dwell lowered mid-count expires on the next edge.
  assign tick = run & (r_cnt >= dwell);
  always_ff @(posedge clk) begin
    if (rst || clear) r_cnt <= '0;
    else if (run) r_cnt <= tick ? '0 : r_cnt + DWELL_W'(1);
  end
endmodule

// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered binary-to-one-hot decoder with enable, polarity and auto-scan
//   clk, rst : clock, synchronous active-high reset
//   i_en     : 1 drives decoded output, 0 forces inactive and freezes idx/dwell
//   i_mode   : 0 direct (decode i_sel), 1 scan (internal walk)
//   i_sel    : direct-mode index
//   i_dwell  : scan holds each index for i_dwell+1 cycles
//   o_out    : registered one-hot (inverted when ACTIVE_LOW)
//   o_idx    : registered current index
//   o_wrap   : one-cycle pulse when scan wraps from N-1 to 0
module onehot_scan_decoder
  import onehot_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [DWELL_W-1:0]    i_dwell,
  output logic [(1<<SEL_W)-1:0] o_out,
  output logic [SEL_W-1:0]      o_idx,
  output logic                  o_wrap
);
  localparam int N = 1 << SEL_W;
  localparam logic [N-1:0] INACTIVE = {N{ACTIVE_LOW}};
  logic             w_run;
  logic             w_clear;
  logic             w_tick;
  logic [SEL_W-1:0] w_next_idx;
  logic [N-1:0]     w_dec;
  logic [N-1:0]     r_out;
  logic [SEL_W-1:0] r_idx;
  logic             r_wrap;
  assign w_run   = i_en & i_mode;
  assign w_clear = i_en & ~i_mode;
  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .run  (w_run),
    .clear(w_clear),
    .dwell(i_dwell),
    .tick (w_tick)
  );
  // Mode is checked before the tick so a direct-mode edge always wins.
  always_comb begin
    w_next_idx = !i_en ? r_idx : !i_mode ? i_sel : w_tick ? r_idx + SEL_W'(1) : r_idx;
    w_dec      = N'(onehot(32'(w_next_idx), onehot_n(SEL_W)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_out  <= INACTIVE;
      r_wrap <= 1'b0;
    end else begin
      r_idx  <= w_next_idx;
      r_out  <= i_en ? (w_dec ^ INACTIVE) : INACTIVE;
      r_wrap <= w_run & w_tick & (&r_idx);
    end
  end
  assign o_out  = r_out;
  assign o_idx  = r_idx;
  assign o_wrap = r_wrap;
endmodule
